mem_bus_arbiter: RTL and testbench

- Shares the core's single memory bus between two requesters: instruction fetch (I-port) and the memory stage (D-port).
- Sits between the fetch/memory stages and the external bus.
- The hazard controller consumes i_resp_ok/d_resp_ok as the "invalid" stall source: a stage stalls while its request is outstanding.
- Priority goes to D-port, with a starvation guard for I-port.

---
 rtl/mem_bus_arbiter_if.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared memory bus seen by mem_bus_arbiter.
// Handshake: a requester holds x_req and its fields until x_resp_ok pulses for one cycle; the arbiter
// holds m_req and m_* stable until m_ok pulses for one cycle, and m_rdata is valid only alongside m_ok.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp_ok;
  logic [DATA_W-1:0] i_rdata;

  logic                i_unused_pad;
  logic                d_req;
  logic [ADDR_W-1:0]   d_addr;
  logic                d_we;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_strobe;
  logic [2:0]          d_size;
  logic                d_resp_ok;
  logic [DATA_W-1:0]   d_rdata;

  logic                m_req;
  logic [ADDR_W-1:0]   m_addr;
  logic                m_we;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_strobe;
  logic [2:0]          m_size;
  logic                m_ok;
  logic [DATA_W-1:0]   m_rdata;

  // Arbiter side.
  modport master (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_strobe, d_size, m_ok, m_rdata,
    output i_resp_ok, i_rdata, d_resp_ok, d_rdata,
    output m_req, m_addr, m_we, m_wdata, m_strobe, m_size
  );

  // Requester and memory side.
  modport slave (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, d_strobe, d_size, m_ok, m_rdata,
    input  i_resp_ok, i_rdata, d_resp_ok, d_rdata,
    input  m_req, m_addr, m_we, m_wdata, m_strobe, m_size
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch (I) and memory stage (D): D has priority, I is forced
// after MAX_D_STREAK back-to-back D grants. Optional bus timeout is built when ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus,
  output logic              timeout_err,
  output logic [1:0]        fsm_state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int STRB_W = DATA_W / 8;

  state_t              state, state_n;
  logic [3:0]          streak, streak_n;
  logic                grant_i, grant_d;
  logic                expire;
  logic                i_ok, d_ok;
  logic [DATA_W-1:0]   resp_data;

  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strobe_q;
  logic [2:0]          size_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_n;
      streak <= streak_n;
    end
  end

  always_comb begin
    state_n  = state;
    streak_n = streak;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    i_ok     = 1'b0;
    d_ok     = 1'b0;
    case (state)
      IDLE: begin
        // The streak only grows while I is actually waiting; an uncontested D grant restarts it.
        if (bus.d_req && (!bus.i_req || (streak < 4'(MAX_D_STREAK)))) begin
          state_n  = BUSY_D;
          grant_d  = 1'b1;
          streak_n = bus.i_req ? streak + 4'd1 : 4'd0;
        end else if (bus.i_req) begin
          state_n  = BUSY_I;
          grant_i  = 1'b1;
          streak_n = 4'd0;
        end
      end
      BUSY_I: begin
        if (bus.m_ok || expire) begin
          i_ok    = 1'b1;
          state_n = IDLE;
        end
      end
      BUSY_D: begin
        if (bus.m_ok || expire) begin
          d_ok    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus fields come only from these registers so requester changes mid-transaction are invisible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
      size_q   <= 3'd0;
    end else if (grant_d) begin
      addr_q   <= bus.d_addr;
      we_q     <= bus.d_we;
      wdata_q  <= bus.d_wdata;
      strobe_q <= bus.d_strobe;
      size_q   <= bus.d_size;
    end else if (grant_i) begin
      addr_q   <= bus.i_addr;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      strobe_q <= '0;
      size_q   <= 3'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ok) i_rdata_q <= resp_data;
      if (d_ok) d_rdata_q <= resp_data;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (grant_i || grant_d) begin
      wait_cnt <= '0;
    end else if (state != IDLE) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Counter is 0 in the first busy cycle, so m_req is held for exactly TIMEOUT cycles before abort.
  assign expire      = (state != IDLE) && !bus.m_ok && (wait_cnt == 8'(TIMEOUT - 1));
  assign timeout_err = expire;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign resp_data = expire ? '0 : bus.m_rdata;

  assign bus.m_req     = (state != IDLE);
  assign bus.m_addr    = addr_q;
  assign bus.m_we      = we_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_strobe  = strobe_q;
  assign bus.m_size    = size_q;

  assign bus.i_resp_ok = i_ok;
  assign bus.d_resp_ok = d_ok;
  assign bus.i_rdata   = i_ok ? resp_data : i_rdata_q;
  assign bus.d_rdata   = d_ok ? resp_data : d_rdata_q;

  assign fsm_state = state;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; timeout scenarios are included when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       timeout_err;
  logic [1:0] fsm_state;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_D_STREAK(4), .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .timeout_err(timeout_err),
    .fsm_state(fsm_state)
  );

  // Inputs change 1ns after a rising edge; outputs are checked 1ns later, far from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_wdata = '0;
    bus.d_strobe = '0; bus.d_size = 3'd0;
    bus.m_ok = 1'b0; bus.m_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    bus.m_ok = 1'b1;
    bus.m_rdata = 64'hFFFF;
    repeat (3) next_cycle();
    #1;
    n_cmp++;
    if ({bus.m_req, bus.m_we, bus.m_strobe, bus.m_size, fsm_state} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got req=%0b we=%0b strb=%h size=%0d st=%0d required all 0",
               bus.m_req, bus.m_we, bus.m_strobe, bus.m_size, fsm_state);
    end
    n_cmp++;
    if ((bus.m_addr | bus.m_wdata) !== 64'd0) begin
      n_bad++; $display("FAIL reset_bus: addr=%h wdata=%h required 0", bus.m_addr, bus.m_wdata);
    end
    n_cmp++;
    if ({bus.i_resp_ok, bus.d_resp_ok, timeout_err} !== 3'b000 || (bus.i_rdata | bus.d_rdata) !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_resp: iok=%0b dok=%0b terr=%0b ird=%h drd=%h required 0",
               bus.i_resp_ok, bus.d_resp_ok, timeout_err, bus.i_rdata, bus.d_rdata);
    end
    bus.m_ok = 1'b0;
    bus.m_rdata = '0;
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    next_cycle();
    bus.i_req = 1'b1;
    bus.i_addr = 64'h8000_0000;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_lat: m_req=%0b required 0", bus.m_req); end
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h8000_0000 || bus.m_we !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_issue: req=%0b addr=%h we=%0b required 1 80000000 0", bus.m_req, bus.m_addr, bus.m_we);
    end
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1) begin n_bad++; $display("FAIL fetch_hold: m_req=%0b required 1", bus.m_req); end
    next_cycle();
    bus.m_ok = 1'b1;
    bus.m_rdata = 64'h13;
    #1;
    n_cmp++;
    if (bus.i_resp_ok !== 1'b1 || bus.i_rdata !== 64'h13 || bus.d_resp_ok !== 1'b0 || bus.m_req !== 1'b1) begin
      n_bad++;
      $display("FAIL fetch_resp: iok=%0b ird=%h dok=%0b req=%0b required 1 13 0 1",
               bus.i_resp_ok, bus.i_rdata, bus.d_resp_ok, bus.m_req);
    end
    next_cycle();
    bus.m_ok = 1'b0;
    bus.i_req = 1'b0;
    bus.m_rdata = 64'hAA;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0 || bus.i_resp_ok !== 1'b0 || bus.i_rdata !== 64'h13) begin
      n_bad++;
      $display("FAIL fetch_done: req=%0b iok=%0b ird=%h required 0 0 13", bus.m_req, bus.i_resp_ok, bus.i_rdata);
    end
  endtask

  task automatic test_d_priority();
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 64'h3000;
    bus.d_req = 1'b1; bus.d_addr = 64'h4000; bus.d_we = 1'b1;
    bus.d_wdata = 64'hDEAD; bus.d_strobe = 8'h0F; bus.d_size = 3'd2;
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h4000 || bus.m_we !== 1'b1 || bus.m_wdata !== 64'hDEAD ||
        bus.m_strobe !== 8'h0F || bus.m_size !== 3'd2) begin
      n_bad++;
      $display("FAIL prio_d_fields: req=%0b addr=%h we=%0b wd=%h strb=%h size=%0d required 1 4000 1 dead 0f 2",
               bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata, bus.m_strobe, bus.m_size);
    end
    bus.m_ok = 1'b1;
    #1;
    n_cmp++;
    if ({bus.i_resp_ok, bus.d_resp_ok} !== 2'b01) begin
      n_bad++; $display("FAIL prio_d_resp: iok/dok=%b required 01", {bus.i_resp_ok, bus.d_resp_ok});
    end
    next_cycle();
    bus.m_ok = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0) begin n_bad++; $display("FAIL prio_bubble: m_req=%0b required 0", bus.m_req); end
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h3000 || bus.m_we !== 1'b0 || bus.m_strobe !== 8'h00 ||
        bus.m_size !== 3'd3) begin
      n_bad++;
      $display("FAIL prio_i_fields: req=%0b addr=%h we=%0b strb=%h size=%0d required 1 3000 0 00 3",
               bus.m_req, bus.m_addr, bus.m_we, bus.m_strobe, bus.m_size);
    end
    bus.m_ok = 1'b1;
    bus.m_rdata = 64'h77;
    #1;
    n_cmp++;
    if ({bus.i_resp_ok, bus.d_resp_ok} !== 2'b10 || bus.i_rdata !== 64'h77) begin
      n_bad++;
      $display("FAIL prio_i_resp: iok/dok=%b ird=%h required 10 77", {bus.i_resp_ok, bus.d_resp_ok}, bus.i_rdata);
    end
    next_cycle();
    bus.m_ok = 1'b0; bus.i_req = 1'b0;
  endtask

  task automatic test_streak();
    logic [9:0] exp_is_i;
    logic       found;
    exp_is_i = 10'b10_0001_0000;
    bus.i_req = 1'b1; bus.i_addr = 64'h1000;
    bus.d_req = 1'b1; bus.d_addr = 64'h2000; bus.d_we = 1'b0;
    for (int g = 0; g < 10; g++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        next_cycle();
        bus.m_ok = 1'b0;
        #1;
        if (bus.m_req === 1'b1) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
        n_bad++; $display("FAIL streak_wait: grant %0d never issued m_req", g);
        break;
      end
      n_cmp++;
      if (bus.m_addr !== (exp_is_i[g] ? 64'h1000 : 64'h2000)) begin
        n_bad++;
        $display("FAIL streak_order: grant %0d addr=%h required %h", g, bus.m_addr,
                 exp_is_i[g] ? 64'h1000 : 64'h2000);
      end
      next_cycle();
      bus.m_ok = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp_ok, bus.d_resp_ok} !== (exp_is_i[g] ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL streak_resp: grant %0d iok/dok=%b required %b", g, {bus.i_resp_ok, bus.d_resp_ok},
                 exp_is_i[g] ? 2'b10 : 2'b01);
      end
    end
    next_cycle();
    bus.m_ok = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_addr_hold();
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 64'h100; bus.d_we = 1'b0;
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_addr !== 64'h100) begin n_bad++; $display("FAIL hold_issue: addr=%h required 100", bus.m_addr); end
    bus.d_addr = 64'h200;
    next_cycle();
    bus.d_req = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_addr !== 64'h100 || bus.m_req !== 1'b1) begin
      n_bad++; $display("FAIL hold_mid: addr=%h req=%0b required 100 1", bus.m_addr, bus.m_req);
    end
    next_cycle();
    bus.m_ok = 1'b1; bus.m_rdata = 64'hBEEF;
    #1;
    n_cmp++;
    if (bus.d_resp_ok !== 1'b1 || bus.d_rdata !== 64'hBEEF || bus.m_addr !== 64'h100) begin
      n_bad++;
      $display("FAIL hold_resp: dok=%0b drd=%h addr=%h required 1 beef 100", bus.d_resp_ok, bus.d_rdata, bus.m_addr);
    end
    next_cycle();
    bus.m_rdata = 64'h999;
    #1;
    n_cmp++;
    if ({bus.i_resp_ok, bus.d_resp_ok, bus.m_req} !== 3'b000 || bus.d_rdata !== 64'hBEEF) begin
      n_bad++;
      $display("FAIL idle_mok: iok=%0b dok=%0b req=%0b drd=%h required 0 0 0 beef",
               bus.i_resp_ok, bus.d_resp_ok, bus.m_req, bus.d_rdata);
    end
    next_cycle();
    bus.m_ok = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0 || fsm_state !== 2'd0) begin
      n_bad++; $display("FAIL idle_stay: req=%0b st=%0d required 0 0", bus.m_req, fsm_state);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 64'h40;
    next_cycle(); #1;
    n_cmp++;
    if (bus.m_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: m_req=%0b required 1", bus.m_req); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0 || fsm_state !== 2'd0) begin
      n_bad++; $display("FAIL rstmid_async: req=%0b st=%0d required 0 0", bus.m_req, fsm_state);
    end
    bus.m_ok = 1'b1; bus.m_rdata = 64'h5A;
    #1;
    n_cmp++;
    if (bus.i_resp_ok !== 1'b0 || bus.i_rdata !== 64'd0) begin
      n_bad++; $display("FAIL rstmid_noresp: iok=%0b ird=%h required 0 0", bus.i_resp_ok, bus.i_rdata);
    end
    next_cycle();
    bus.i_req = 1'b0; bus.m_ok = 1'b0; reset = 1'b1;
    next_cycle(); #1;
    n_cmp++;
    if (fsm_state !== 2'd0 || bus.m_req !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_release: st=%0d req=%0b required 0 0", fsm_state, bus.m_req);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout(input logic ok_on_expiry);
    next_cycle();
    bus.d_req = 1'b1; bus.d_addr = 64'h500; bus.d_we = 1'b0;
    for (int k = 1; k < 10; k++) begin
      next_cycle(); #1;
      n_cmp++;
      if ({timeout_err, bus.d_resp_ok, bus.m_req} !== 3'b001) begin
        n_bad++;
        $display("FAIL tmo_wait: cycle %0d terr=%0b dok=%0b req=%0b required 0 0 1",
                 k, timeout_err, bus.d_resp_ok, bus.m_req);
      end
    end
    next_cycle();
    bus.m_ok = ok_on_expiry; bus.m_rdata = 64'h55;
    #1;
    n_cmp++;
    if (timeout_err !== !ok_on_expiry || bus.d_resp_ok !== 1'b1 ||
        bus.d_rdata !== (ok_on_expiry ? 64'h55 : 64'h0)) begin
      n_bad++;
      $display("FAIL tmo_expiry: terr=%0b dok=%0b drd=%h required %0b 1 %h", timeout_err, bus.d_resp_ok,
               bus.d_rdata, !ok_on_expiry, ok_on_expiry ? 64'h55 : 64'h0);
    end
    next_cycle();
    bus.d_req = 1'b0; bus.m_ok = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_req !== 1'b0 || timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_after: req=%0b terr=%0b required 0 0", bus.m_req, timeout_err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_d_priority();
    test_streak();
    test_addr_hold();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout(1'b0);
    test_timeout(1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
